// File: rtl/regfile_pkg.sv
// Shared constants for the general-purpose register file, also used by decode and writeback.
// State encoding, zero-register address, default geometry and an address-range helper.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned RF_ZERO_ADDR     = 0;
  localparam int          RF_DEFAULT_DW    = 32;
  localparam int          RF_DEFAULT_DEPTH = 32;

  // True for a register that has real storage: not r0 and inside the file.
  function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned depth);
    return (addr != RF_ZERO_ADDR) && (addr < depth);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy vector for the register file (built only with REGFILE_SCOREBOARD_EN).
// A set marks a register whose producer has issued; a write-back clears it; a same-cycle set wins.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic [NWR-1:0]    wr_ok_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
);

  logic [DEPTH-1:0] sb_q;
  logic [DEPTH-1:0] sb_d;
  logic             set_ok;
  logic             wr_hit;
  logic             set_hit;

  assign set_ok = run_i && set_en_i && rf_addr_ok(32'(set_addr_i), DEPTH);

  always_comb begin
    sb_d = sb_q;
    for (int i = 0; i < NWR; i++) begin
      if (wr_ok_i[i]) sb_d[wr_addr_i[i*AW +: AW]] = 1'b0;
    end
    if (set_ok) sb_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  // A write-back landing this cycle hides the busy bit unless a newer producer claims the register.
  always_comb begin
    rd_busy_o = '0;
    wr_hit    = 1'b0;
    set_hit   = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      wr_hit  = 1'b0;
      set_hit = set_ok && (set_addr_i == rd_addr_i[j*AW +: AW]);
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok_i[i] && (wr_addr_i[i*AW +: AW] == rd_addr_i[j*AW +: AW])) wr_hit = 1'b1;
      end
      if (run_i && rf_addr_ok(32'(rd_addr_i[j*AW +: AW]), DEPTH)) begin
        rd_busy_o[j] = sb_q[rd_addr_i[j*AW +: AW]] && (!wr_hit || set_hit);
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports with write bypass, NWR write ports,
// r0 hardwired to zero, post-reset clear sweep. Macro REGFILE_SCOREBOARD_EN adds the busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW    = RF_DEFAULT_DW,
  parameter int DEPTH = RF_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*DW-1:0] wr_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              sb_set_en,
  input  logic [AW-1:0]     sb_set_addr,
  output logic              ready,
  output rf_state_e         dbg_state
);

  rf_state_e      state_q;
  rf_state_e      state_d;
  logic [AW-1:0]  clr_idx_q;
  logic [AW-1:0]  clr_idx_d;
  logic           ready_q;
  logic           ready_d;
  logic           run;
  logic [NWR-1:0] wr_ok;
  logic [DW-1:0]  mem_q [DEPTH];

  assign run       = (state_q == RF_RUN);
  assign ready     = ready_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // ready is the registered image of the next state, so it rises the cycle after the last clear.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    if (state_q == RF_CLEAR) begin
      if (clr_idx_q == AW'(DEPTH - 1)) begin
        state_d = RF_RUN;
      end else begin
        clr_idx_d = clr_idx_q + AW'(1);
      end
    end
    ready_d = (state_d == RF_RUN);
  end

  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < NWR; i++) begin
      wr_ok[i] = run && wr_en[i] && rf_addr_ok(32'(wr_addr[i*AW +: AW]), DEPTH);
    end
  end

  // Ascending port order lets the highest-index port win a same-address collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok[i]) mem_q[wr_addr[i*AW +: AW]] <= wr_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < NRD; j++) begin
      if (run && rf_addr_ok(32'(rd_addr[j*AW +: AW]), DEPTH)) begin
        rd_data[j*DW +: DW] = mem_q[rd_addr[j*AW +: AW]];
        for (int i = 0; i < NWR; i++) begin
          if (wr_ok[i] && (wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW])) begin
            rd_data[j*DW +: DW] = wr_data[i*DW +: DW];
          end
        end
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  rf_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .set_en_i   (sb_set_en),
    .set_addr_i (sb_set_addr),
    .wr_ok_i    (wr_ok),
    .wr_addr_i  (wr_addr),
    .rd_addr_i  (rd_addr),
    .rd_busy_o  (rd_busy)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set_en, sb_set_addr};
  assign rd_busy   = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (NWR=2, NRD=2): directed vectors, expected reads queued by the stimulus
// and checked on the falling edge by a separate monitor.
`timescale 1ns/1ps
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int W     = DW + 3;  // {port, ready, busy, data}
`ifdef REGFILE_SCOREBOARD_EN
  localparam logic SB_ON = 1'b1;
`else
  localparam logic SB_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              sb_set_en;
  logic [AW-1:0]     sb_set_addr;
  logic              ready;
  rf_state_e         dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_pass  = 0;
  int           n_total = 0;

  regfile_mp #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .NWR(NWR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .ready       (ready),
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
  endtask

  task automatic drv_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*DW +: DW]  = d;
  endtask

  task automatic drv_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic drv_set(input logic [AW-1:0] a);
    sb_set_en   = 1'b1;
    sb_set_addr = a;
  endtask

  task automatic expect_rd(input int p, input logic [DW-1:0] d, input logic b, input logic r,
                           input string nm);
    exp_q.push_back({1'(p), r, b, d});
    name_q.push_back(nm);
  endtask

  // Holds a0 under write/set attempts through the whole sweep; everything must read 0 and not busy.
  task automatic sweep_phase(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    for (int k = 0; k <= 31; k++) begin
      idle();
      if (k < 31) begin
        drv_wr(0, a0, 32'hAAAA_0000 + 32'(k));
        drv_set(a0);
      end
      drv_rd(0, a0);
      drv_rd(1, a1);
      expect_rd(0, '0, 1'b0, (k == 31), $sformatf("%s_k%0d_p0", tag, k));
      expect_rd(1, '0, 1'b0, (k == 31), $sformatf("%s_k%0d_p1", tag, k));
      tick();
    end
    idle();
  endtask

  // scoreboard monitor
  logic [W-1:0]  mon_e;
  string         mon_nm;
  int            mon_p;
  logic [DW-1:0] mon_d;
  logic          mon_b;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      mon_p  = int'(mon_e[W-1]);
      mon_d  = rd_data[mon_p*DW +: DW];
      mon_b  = rd_busy[mon_p];
      n_total++;
      if (mon_d === mon_e[DW-1:0] && mon_b === mon_e[DW] && ready === mon_e[DW+1]) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got data=%h busy=%b ready=%b, expected data=%h busy=%b ready=%b",
                 mon_nm, mon_d, mon_b, ready, mon_e[DW-1:0], mon_e[DW], mon_e[DW+1]);
      end
    end
  end

  // stimulus
  initial begin
    idle();
    rd_addr = '0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    sweep_phase("sweep", 5'd5, 5'd6);

    for (int a = 1; a <= 31; a++) begin
      drv_rd(0, 5'(a));
      drv_rd(1, 5'(32 - a));
      expect_rd(0, '0, 1'b0, 1'b1, $sformatf("zero_r%0d", a));
      expect_rd(1, '0, 1'b0, 1'b1, $sformatf("zero_r%0d", 32 - a));
      tick();
    end

    // write/read, bypass, r0
    idle();
    drv_wr(0, 5'd3, 32'hDEAD_BEEF);
    drv_wr(1, 5'd0, 32'h0000_1234);
    drv_rd(0, 5'd3);
    drv_rd(1, 5'd0);
    expect_rd(0, 32'hDEAD_BEEF, 1'b0, 1'b1, "r3_bypass");
    expect_rd(1, '0, 1'b0, 1'b1, "r0_bypass");
    tick();
    idle();
    expect_rd(0, 32'hDEAD_BEEF, 1'b0, 1'b1, "r3_array");
    expect_rd(1, '0, 1'b0, 1'b1, "r0_array");
    tick();

    // write-port priority
    drv_wr(0, 5'd7, 32'h0000_0011);
    drv_wr(1, 5'd7, 32'h0000_0022);
    drv_rd(0, 5'd7);
    drv_rd(1, 5'd3);
    expect_rd(0, 32'h0000_0022, 1'b0, 1'b1, "prio_bypass");
    expect_rd(1, 32'hDEAD_BEEF, 1'b0, 1'b1, "r3_unaffected");
    tick();
    idle();
    drv_rd(1, 5'd7);
    expect_rd(0, 32'h0000_0022, 1'b0, 1'b1, "prio_array_p0");
    expect_rd(1, 32'h0000_0022, 1'b0, 1'b1, "prio_array_p1");
    tick();

    // two ports, distinct addresses incl. top entry; then a single-port overwrite
    drv_wr(0, 5'd10, 32'hA0A0_A0A0);
    drv_wr(1, 5'd31, 32'h3131_3131);
    drv_rd(0, 5'd10);
    drv_rd(1, 5'd31);
    expect_rd(0, 32'hA0A0_A0A0, 1'b0, 1'b1, "r10_bypass");
    expect_rd(1, 32'h3131_3131, 1'b0, 1'b1, "r31_bypass");
    tick();
    idle();
    drv_wr(0, 5'd7, 32'h0000_0033);
    drv_rd(1, 5'd7);
    expect_rd(0, 32'hA0A0_A0A0, 1'b0, 1'b1, "r10_array");
    expect_rd(1, 32'h0000_0033, 1'b0, 1'b1, "r7_overwrite_bypass");
    tick();
    idle();
    drv_rd(0, 5'd31);
    expect_rd(0, 32'h3131_3131, 1'b0, 1'b1, "r31_array");
    expect_rd(1, 32'h0000_0033, 1'b0, 1'b1, "r7_overwrite_array");
    tick();

    // scoreboard
    idle();
    drv_set(5'd4);
    drv_rd(0, 5'd4);
    drv_rd(1, 5'd0);
    expect_rd(0, '0, 1'b0, 1'b1, "sb_set_cycle");
    tick();
    idle();
    drv_set(5'd0);
    expect_rd(0, '0, SB_ON, 1'b1, "sb_busy_next");
    tick();
    idle();
    drv_wr(0, 5'd4, 32'h0000_0099);
    expect_rd(0, 32'h0000_0099, 1'b0, 1'b1, "sb_write_clears");
    expect_rd(1, '0, 1'b0, 1'b1, "sb_r0_never_busy");
    tick();
    idle();
    drv_set(5'd4);
    expect_rd(0, 32'h0000_0099, 1'b0, 1'b1, "sb_after_clear");
    tick();
    idle();
    expect_rd(0, 32'h0000_0099, SB_ON, 1'b1, "sb_reset_busy");
    tick();
    drv_set(5'd4);
    drv_wr(1, 5'd4, 32'h0000_0077);
    expect_rd(0, 32'h0000_0077, SB_ON, 1'b1, "sb_set_write_same");
    tick();
    idle();
    expect_rd(0, 32'h0000_0077, SB_ON, 1'b1, "sb_set_wins");
    tick();
    drv_wr(0, 5'd4, 32'h0000_0088);
    expect_rd(0, 32'h0000_0088, 1'b0, 1'b1, "sb_write_only");
    tick();
    idle();
    expect_rd(0, 32'h0000_0088, 1'b0, 1'b1, "sb_cleared");
    tick();

    // reset mid-run with r4 busy and r9 written
    drv_wr(0, 5'd9, 32'h0000_0055);
    drv_set(5'd4);
    drv_rd(0, 5'd9);
    drv_rd(1, 5'd4);
    expect_rd(0, 32'h0000_0055, 1'b0, 1'b1, "r9_bypass");
    expect_rd(1, 32'h0000_0088, 1'b0, 1'b1, "r4_set_cycle");
    tick();
    idle();
    rst = 1'b1;
    expect_rd(0, 32'h0000_0055, 1'b0, 1'b1, "r9_before_rst");
    expect_rd(1, 32'h0000_0088, SB_ON, 1'b1, "r4_busy_before_rst");
    tick();
    rst = 1'b0;
    sweep_phase("midrst", 5'd9, 5'd4);

    drv_rd(0, 5'd3);
    drv_rd(1, 5'd31);
    expect_rd(0, '0, 1'b0, 1'b1, "r3_cleared");
    expect_rd(1, '0, 1'b0, 1'b1, "r31_cleared");
    tick();

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
